// File: rtl/seq_alu.sv
// Registered ALU: legacy single-cycle ops plus SLL/SRA/SLTU and iterative
// unsigned multiply/divide behind a start/ready/done handshake.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int SH = $clog2(WIDTH);
  localparam logic [SH-1:0] CNT_LAST = SH'(WIDTH - 1);
  localparam logic [SH-1:0] CNT_ONE  = SH'(1);

  typedef enum logic [3:0] {
    OP_AND  = 4'h0, OP_OR   = 4'h1, OP_ADD  = 4'h2, OP_XOR  = 4'h3,
    OP_NOR  = 4'h4, OP_SRL  = 4'h5, OP_SUB  = 4'h6, OP_SLT  = 4'h7,
    OP_SLL  = 4'h8, OP_SRA  = 4'h9, OP_SLTU = 4'hA, OP_MULU = 4'hB,
    OP_DIVU = 4'hC
  } op_e;

  typedef enum logic {IDLE, ITER} state_e;

  state_e           state;
  logic [SH-1:0]    cnt;
  logic             is_div;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic [SH-1:0]    sh;
  logic [WIDTH-1:0] add_r, sub_r;
  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             sc_ovf, sc_dbz;
  logic             go_iter;

  assign sh      = b[SH-1:0];
  assign add_r   = a + b;
  assign sub_r   = a - b;
  assign ready   = (state == IDLE);
  assign go_iter = (op == OP_MULU) || ((op == OP_DIVU) && (b != '0));

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    sc_res = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    sc_dbz = 1'b0;
    case (op_e'(op))
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_ADD: begin
        sc_res = add_r;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_SRL:  sc_res = a >> sh;
      OP_SUB: begin
        sc_res = sub_r;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLL:  sc_res = a << sh;
      OP_SRA:  sc_res = $signed(a) >>> sh;
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_DIVU: begin
        // Only the b==0 case finishes in one cycle.
        sc_res = '1;
        sc_hi  = a;
        sc_dbz = 1'b1;
      end
      default: ;
    endcase
  end

  // One iteration step. MULU: {acc_hi,acc_lo} holds {partial product,
  // remaining multiplier bits}. DIVU: acc_hi is the partial remainder and
  // acc_lo shifts dividend bits out while quotient bits shift in.
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] hi_n, lo_n;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, op_b};
    div_ge    = ~div_diff[WIDTH];
    if (is_div) begin
      hi_n = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_n = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      op_b        <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      done        <= 1'b0;
      res         <= '0;
      res_hi      <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (go_iter) begin
              is_div <= (op == OP_DIVU);
              op_b   <= b;
              acc_hi <= '0;
              acc_lo <= a;
              cnt    <= CNT_LAST;
              state  <= ITER;
            end else begin
              res         <= sc_res;
              res_hi      <= sc_hi;
              zero        <= (sc_res == '0);
              overflow    <= sc_ovf;
              div_by_zero <= sc_dbz;
              done        <= 1'b1;
            end
          end
        end
        ITER: begin
          acc_hi <= hi_n;
          acc_lo <= lo_n;
          cnt    <= cnt - CNT_ONE;
          if (cnt == '0) begin
            res         <= lo_n;
            res_hi      <= hi_n;
            zero        <= (lo_n == '0);
            overflow    <= !is_div && (hi_n != '0);
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: a cycle-level behavioural model compared
// every cycle, directed literal cases, then randomized traffic.
module tb_seq_alu;

  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op    = '0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         ready, done, zero, overflow, div_by_zero;
  logic [W-1:0] res, res_hi;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .res(res), .res_hi(res_hi),
    .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic         z;
    logic         o;
    logic         d;
  } out_t;

  // Reference results straight from the arithmetic definitions.
  function automatic out_t ref_op(input logic [3:0] o_op, input logic [W-1:0] x, input logic [W-1:0] y);
    out_t t;
    longint sx, sy, s;
    longint unsigned p;
    int sh;
    t  = '0;
    sx = $signed(x);
    sy = $signed(y);
    sh = int'(y[4:0]);
    case (o_op)
      4'h0: t.r = x & y;
      4'h1: t.r = x | y;
      4'h2: begin s = sx + sy; t.r = x + y; t.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'h3: t.r = x ^ y;
      4'h4: t.r = ~(x | y);
      4'h5: t.r = x >> sh;
      4'h6: begin s = sx - sy; t.r = x - y; t.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'h7: t.r = (sx < sy) ? 1 : 0;
      4'h8: t.r = x << sh;
      4'h9: t.r = $signed(x) >>> sh;
      4'hA: t.r = (x < y) ? 1 : 0;
      4'hB: begin
        p   = {32'b0, x} * {32'b0, y};
        t.r = p[31:0];
        t.h = p[63:32];
        t.o = (t.h != 0);
      end
      4'hC: begin
        if (y == 0) begin t.r = '1; t.h = x; t.d = 1'b1; end
        else begin t.r = x / y; t.h = x % y; end
      end
      default: ;
    endcase
    t.z = (t.r == 0);
    return t;
  endfunction

  function automatic bit is_iter(input logic [3:0] o_op, input logic [W-1:0] y);
    return (o_op == 4'hB) || (o_op == 4'hC && y != 0);
  endfunction

  // Model: busy counts remaining cycles of an iterative op.
  int   m_busy = 0;
  logic m_done = 1'b0;
  out_t m_out  = '0;
  out_t pend   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0;
      m_done <= 1'b0;
      m_out  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_out  <= pend;
          m_done <= 1'b1;
        end
      end else if (start) begin
        if (is_iter(op, b)) begin
          m_busy <= W;
          pend   <= ref_op(op, a, b);
        end else begin
          m_out  <= ref_op(op, a, b);
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("ready", {63'b0, ready}, {63'b0, m_busy == 0});
    check("done", {63'b0, done}, {63'b0, m_done});
    check("res", {res_hi, res}, {m_out.h, m_out.r});
    check("flags", {61'b0, zero, overflow, div_by_zero}, {61'b0, m_out.z, m_out.o, m_out.d});
  end

  task automatic launch(input logic [3:0] o_op, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o_op;
    a     = x;
    b     = y;
    @(posedge clk);
  endtask

  // Counts cycles after the start edge until done, bounded.
  task automatic wait_done(input bit spam, output int n, output int low);
    n   = 0;
    low = 0;
    do begin
      @(negedge clk);
      n++;
      if (spam && n >= 2 && n <= 10) begin
        start = 1'b1;
        op    = 4'h2;
        a     = $urandom;
        b     = $urandom;
      end else begin
        start = 1'b0;
      end
      if (!ready) low++;
    end while (!done && n < 200);
  endtask

  task automatic check_out(input string name, input logic [W-1:0] er, input logic [W-1:0] eh,
                           input logic [2:0] ef);
    check({name, " res"}, {32'b0, res}, {32'b0, er});
    check({name, " res_hi"}, {32'b0, res_hi}, {32'b0, eh});
    check({name, " flags"}, {61'b0, zero, overflow, div_by_zero}, {61'b0, ef});
  endtask

  task automatic run_op(input string name, input logic [3:0] o_op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int lat, input logic [W-1:0] er,
                        input logic [W-1:0] eh, input logic [2:0] ef);
    int n, low;
    launch(o_op, x, y);
    wait_done(1'b0, n, low);
    check({name, " latency"}, n, lat);
    check_out(name, er, eh, ef);
  endtask

  initial begin
    int n, low;
    repeat (3) @(negedge clk);
    check_out("reset", '0, '0, 3'b000);
    check("reset ready", {63'b0, ready}, 64'd1);
    check("reset done", {63'b0, done}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Legacy sweep; flags are {zero, overflow, div_by_zero}.
    run_op("AND", 4'h0, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'h00000000, 0, 3'b100);
    run_op("OR",  4'h1, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'hFFFFFFFF, 0, 3'b000);
    run_op("ADD", 4'h2, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'hFFFFFFFF, 0, 3'b000);
    run_op("XOR", 4'h3, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'hFFFFFFFF, 0, 3'b000);
    run_op("NOR", 4'h4, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'h00000000, 0, 3'b100);
    run_op("SRL", 4'h5, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'h00000029, 0, 3'b000);
    run_op("SUB", 4'h6, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'h4B4B4B4B, 0, 3'b010);
    run_op("SLT", 4'h7, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'h00000001, 0, 3'b000);
    run_op("SLTU", 4'hA, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'h00000000, 0, 3'b100);
    run_op("RSVD", 4'hE, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'h00000000, 0, 3'b100);

    run_op("ADD ovf", 4'h2, 32'h7FFFFFFF, 32'h00000001, 1, 32'h80000000, 0, 3'b010);
    run_op("SUB eq",  4'h6, 32'h12345678, 32'h12345678, 1, 32'h00000000, 0, 3'b100);

    // MULU with ignored starts during the iteration.
    launch(4'hB, 32'h00010000, 32'h00010000);
    wait_done(1'b1, n, low);
    check("MULU latency", n, 33);
    check("MULU busy cycles", low, 32);
    check_out("MULU", 32'h0, 32'h1, 3'b110);

    run_op("DIVU", 4'hC, 32'd100, 32'd7, 33, 32'd14, 32'd2, 3'b000);
    run_op("DIVU b0", 4'hC, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 32'd5, 3'b001);

    // Reset ten cycles into a MULU.
    launch(4'hB, 32'd3, 32'd5);
    repeat (10) @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset ready", {63'b0, ready}, 64'd1);
    check_out("midreset", '0, '0, 3'b000);
    repeat (3) begin
      @(negedge clk);
      check("midreset done", {63'b0, done}, 64'd0);
    end
    #2 rst_n = 1'b1;
    run_op("post-reset ADD", 4'h2, 32'd1, 32'd2, 1, 32'd3, 0, 3'b000);

    // Back-to-back: DIVU requested in the MULU done cycle.
    launch(4'hB, 32'd3, 32'd5);
    wait_done(1'b0, n, low);
    check("b2b MULU latency", n, 33);
    check_out("b2b MULU", 32'd15, 32'd0, 3'b000);
    start = 1'b1;
    op    = 4'hC;
    a     = 32'd100;
    b     = 32'd7;
    @(posedge clk);
    wait_done(1'b0, n, low);
    check("b2b DIVU latency", n, 33);
    check_out("b2b DIVU", 32'd14, 32'd2, 3'b000);

    run_op("SRA", 4'h9, 32'h80000000, 32'd4, 1, 32'hF8000000, 0, 3'b000);
    run_op("SLL", 4'h8, 32'h00000001, 32'd31, 1, 32'h80000000, 0, 3'b000);
    run_op("SLL hi b", 4'h8, 32'h00000001, 32'h00000021, 1, 32'h00000002, 0, 3'b000);
    run_op("SRL zero", 4'h5, 32'hDEADBEEF, 32'hFFFFFFE0, 1, 32'hDEADBEEF, 0, 3'b000);

    // Randomized traffic; the model tracks acceptance and latency.
    repeat (2500) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op    = 4'($urandom_range(0, 15));
      a     = $urandom;
      b     = $urandom;
      if ($urandom_range(0, 7) == 0) b = $urandom_range(0, 40);
      if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 300);
      if (op == 4'hB && b == 0) b = 32'd1;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered ALU that succeeds the 32-bit combinational ALU (3-bit op, res/zero/overflow).
- Keeps the legacy eight operations as single-cycle ops and adds SLL, SRA and SLTU.
- Adds iterative unsigned multiply and divide, with a start/ready/done handshake.
- Sits between the register file and write-back in the multi-cycle CPU datapath; the controller waits on done.

Parameters:
- WIDTH, 32, operand/result width (>=4, power of two); shift amount SH = $clog2(WIDTH) bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when ready=1
- op  in  4  operation code, sampled with start
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start
- ready  out  1  idle, can accept start
- done  out  1  one-cycle pulse: res/res_hi/flags updated
- res  out  WIDTH  result (MULU low half, DIVU quotient)
- res_hi  out  WIDTH  MULU high half, DIVU remainder, else 0
- zero  out  1  res == 0
- overflow  out  1  see arithmetic rules
- div_by_zero  out  1  DIVU with b == 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready=1.
  - done, res, res_hi, zero, overflow, div_by_zero all 0.
  - Reset mid-operation aborts the operation with no done pulse.
- Opcodes (low three bits keep the legacy encoding):
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR
  - 0101 SRL (a >> b[SH-1:0]), 0110 SUB (a-b), 0111 SLT (signed a<b -> 1)
  - 1000 SLL, 1001 SRA (arithmetic shift), 1010 SLTU
  - 1011 MULU, 1100 DIVU
  - 1101-1111 reserved: res=0, res_hi=0, zero=1, single-cycle.
- FSM states IDLE, ITER:
  - IDLE + start + single-cycle op: at edge E0, outputs register the result, done=1 for the cycle after E0, state stays IDLE.
  - IDLE + start + MULU/DIVU with b!=0: at E0, latch a and b, counter=WIDTH-1, go to ITER, ready=0.
  - ITER: one shift-add (MULU) or restoring shift-subtract (DIVU) step per cycle.
  - ITER completion: on the edge where the counter is 0, write res/res_hi/flags, pulse done, go to IDLE, ready=1.
  - MULU/DIVU latency: done is high in the cycle after edge E0+WIDTH (WIDTH+1 clock edges from the start edge, counting E0).
- DIVU with b==0:
  - Single-cycle.
  - res = all ones, res_hi = a, div_by_zero=1.
- ready and start:
  - ready is combinationally (state==IDLE). It is high during the done cycle, so back-to-back starts are allowed.
  - start while ready=0 is ignored; no queuing.
  - Operands are latched at accept, so a/b/op changes during ITER have no effect.
- Flags are updated only with done and held otherwise; res and res_hi are also held until the next done.
  - zero: res == 0, every op.
  - overflow, ADD: signed overflow (operand signs equal, result sign differs).
  - overflow, SUB: signed overflow (operand signs differ, result sign differs from a).
  - overflow, MULU: res_hi != 0.
  - overflow, all other ops: 0.
  - div_by_zero: 1 only on a DIVU with b==0, else 0.
- Shifts:
  - Only b[SH-1:0] is used; upper bits of b are ignored.
  - A shift amount of 0 returns a.
- Arithmetic is modulo 2^WIDTH; the adder carry-out is discarded.

Test Plan (WIDTH=32):
1. Legacy sweep, a=A5A5A5A5, b=5A5A5A5A, one start per op 0000-0111 -> AND 00000000 zero=1; OR FFFFFFFF; ADD FFFFFFFF ovf=0; XOR FFFFFFFF; NOR 00000000; SRL (b[4:0]=1A) 00000029; SUB 4B4B4B4B ovf=1; SLT 1. Each done is 1 cycle after start; SLTU (1010) -> 0.
2. Signed overflow: ADD 7FFFFFFF+00000001 -> res 80000000, ovf=1, zero=0. SUB 12345678-12345678 -> res 0, zero=1, ovf=0.
3. MULU 00010000*00010000 -> ready=0 for 32 cycles, done 33 edges after start (counting the start edge), res=0, res_hi=00000001, ovf=1, zero=1. Extra starts during ITER are ignored.
4. DIVU 100/7 -> res 14, res_hi 2, div_by_zero=0. DIVU 5/0 -> done after 1 cycle, res FFFFFFFF, res_hi 5, div_by_zero=1.
5. Reset mid-op: pull rst_n low 10 cycles into a MULU -> immediately ready=1 and res/flags=0. No done pulse; a fresh ADD 1+2 afterwards returns 3.
6. Back-to-back: start a DIVU in the done cycle of a MULU -> accepted, with no lost or duplicated done pulse. Shifts: SRA 80000000 by 4 -> F8000000; SLL 1 by 31 -> 80000000.
